// File: rtl/rcn2avalon.sv
// -----------------------------------------------------------------------------
// rcn2avalon
//   rcn ring slave that bridges claimed requests onto an Avalon-MM master port.
//   A request whose address falls in the ADDR_BASE/ADDR_MASK window is removed
//   from the ring and becomes a single Avalon read or write. The matching
//   response is then put back on the ring in the first empty slot. Only one
//   request is handled at a time. Hits that arrive while busy stay on the ring
//   and are serviced when they come round again.
//
//   rcn vector: {valid[68], pending[67], wr[66], id[65:60], mask[59:56],
//                addr[55:34], seq[33:32], data[31:0]}
//
// Ports
//   av_clk            in   clock
//   av_rst_n          in   synchronous active-low reset
//   rcn_in     [68:0] in   ring input
//   rcn_out    [68:0] out  ring output (registered)
//   av_address [21:0] out  Avalon word address (captured request address)
//   av_read           out  Avalon read strobe
//   av_write          out  Avalon write strobe
//   av_byteenable[3:0] out Avalon byte enables (captured request mask)
//   av_writedata[31:0] out Avalon write data (captured request data)
//   av_waitrequest    in   slave stall
//   av_readdata [31:0] in  read data
//   av_readdatavalid  in   read data strobe
//   busy              out  high whenever a request is in flight
//
// Build option
//   RCN2AV_TIMEOUT_EN  when defined, a read that sees no av_readdatavalid for
//                      TIMEOUT_CYCLES cycles completes with data 32'hDEAD_DEAD.
//                      When undefined the bridge waits for read data forever.
// -----------------------------------------------------------------------------
module rcn2avalon #(
   parameter logic [21:0] ADDR_BASE = 22'h000000,
   parameter logic [21:0] ADDR_MASK = 22'h3F0000
`ifdef RCN2AV_TIMEOUT_EN
   ,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
`endif
) (
   input  logic        av_clk,
   input  logic        av_rst_n,
   input  logic [68:0] rcn_in,
   output logic [68:0] rcn_out,
   output logic [21:0] av_address,
   output logic        av_read,
   output logic        av_write,
   output logic [3:0]  av_byteenable,
   output logic [31:0] av_writedata,
   input  logic        av_waitrequest,
   input  logic [31:0] av_readdata,
   input  logic        av_readdatavalid,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_RDWAIT,
      ST_RESP
   } state_t;

   state_t      state;
   logic [68:0] rin;
   logic [68:0] rout;

   // Captured request fields not already held in the Avalon output registers.
   logic        req_wr;
   logic [5:0]  req_id;
   logic [1:0]  req_seq;
   logic [31:0] rdata;

   logic        hit;

`ifdef RCN2AV_TIMEOUT_EN
   logic [15:0] to_cnt;
`endif

   // A slot is ours only if it is a live request (valid and pending) inside
   // the address window; responses and empty slots never match.
   assign hit = rin[68] && rin[67] &&
                ((rin[55:34] & ADDR_MASK) == ADDR_BASE);

   assign rcn_out = rout;

   // NOTE: every register here is updated with non-blocking assignments so
   // that all of them see the pre-edge values of rin and state at once; a
   // blocking write would let later statements observe the new value.
   always_ff @(posedge av_clk) begin
      if (!av_rst_n) begin
         state         <= ST_IDLE;
         rin           <= '0;
         rout          <= '0;
         av_address    <= '0;
         av_read       <= 1'b0;
         av_write      <= 1'b0;
         av_byteenable <= '0;
         av_writedata  <= '0;
         busy          <= 1'b0;
         req_wr        <= 1'b0;
         req_id        <= '0;
         req_seq       <= '0;
         rdata         <= '0;
`ifdef RCN2AV_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         rin <= rcn_in;

         case (state)
            ST_IDLE: begin
               if (hit) begin
                  // Claim the request: take it off the ring and start the
                  // Avalon command on the next cycle.
                  req_wr        <= rin[66];
                  req_id        <= rin[65:60];
                  av_byteenable <= rin[59:56];
                  av_address    <= rin[55:34];
                  req_seq       <= rin[33:32];
                  av_writedata  <= rin[31:0];
                  av_write      <= rin[66];
                  av_read       <= ~rin[66];
                  rout          <= '0;
                  busy          <= 1'b1;
                  state         <= ST_CMD;
               end else begin
                  rout <= rin;
               end
            end

            ST_CMD: begin
               rout <= rin;
               if (!av_waitrequest) begin
                  av_read  <= 1'b0;
                  av_write <= 1'b0;
                  if (req_wr) begin
                     // A write echoes its own data in the response.
                     rdata <= av_writedata;
                     state <= ST_RESP;
                  end else begin
`ifdef RCN2AV_TIMEOUT_EN
                     to_cnt <= '0;
`endif
                     state <= ST_RDWAIT;
                  end
               end
            end

            ST_RDWAIT: begin
               rout <= rin;
               if (av_readdatavalid) begin
                  rdata <= av_readdata;
                  state <= ST_RESP;
               end
`ifdef RCN2AV_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + 16'd1;
                  if (to_cnt + 16'd1 == TIMEOUT_CYCLES) begin
                     rdata <= 32'hDEAD_DEAD;
                     state <= ST_RESP;
                  end
               end
`endif
            end

            ST_RESP: begin
               if (!rin[68]) begin
                  // Empty slot: drop the response in and become free again.
                  rout  <= {1'b1, 1'b0, req_wr, req_id, av_byteenable,
                            av_address, req_seq, rdata};
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  rout <= rin;
               end
            end

            default: begin
               rout  <= rin;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rcn2avalon.sv
// -----------------------------------------------------------------------------
// tb_rcn2avalon
//   Directed bench for rcn2avalon. Ring words are driven on the falling edge
//   and rcn_out / Avalon outputs are sampled on the falling edge, one full
//   cycle after each drive. A small Avalon slave process answers strobes with
//   a programmable number of waitrequest cycles and read-data latency.
// -----------------------------------------------------------------------------
module tb_rcn2avalon;

   logic        av_clk = 1'b0;
   logic        av_rst_n;
   logic [68:0] rcn_in;
   logic [68:0] rcn_out;
   logic [21:0] av_address;
   logic        av_read;
   logic        av_write;
   logic [3:0]  av_byteenable;
   logic [31:0] av_writedata;
   logic        av_waitrequest;
   logic [31:0] av_readdata;
   logic        av_readdatavalid;
   logic        busy;

   always #5 av_clk = ~av_clk;

`ifdef RCN2AV_TIMEOUT_EN
   rcn2avalon #(.TIMEOUT_CYCLES(16'd8)) dut (
`else
   rcn2avalon dut (
`endif
      .av_clk           (av_clk),
      .av_rst_n         (av_rst_n),
      .rcn_in           (rcn_in),
      .rcn_out          (rcn_out),
      .av_address       (av_address),
      .av_read          (av_read),
      .av_write         (av_write),
      .av_byteenable    (av_byteenable),
      .av_writedata     (av_writedata),
      .av_waitrequest   (av_waitrequest),
      .av_readdata      (av_readdata),
      .av_readdatavalid (av_readdatavalid),
      .busy             (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------------------------------------------------------- slave
   int          slv_wait  = 0;
   int          slv_lat   = 1;
   logic        slv_en    = 1'b1;
   logic [31:0] slv_rdata = '0;
   int          hold      = 0;
   int          pend      = 0;
   logic        prev_read = 1'b0;

   initial begin
      av_waitrequest   = 1'b0;
      av_readdata      = '0;
      av_readdatavalid = 1'b0;
      forever begin
         @(negedge av_clk);
         av_readdatavalid = 1'b0;
         if (av_read || av_write) begin
            hold++;
            av_waitrequest = (hold <= slv_wait);
         end else begin
            hold = 0;
            av_waitrequest = 1'b0;
         end
         // Read accepted on the last edge: data returns slv_lat edges later.
         if (prev_read && !av_read) pend = slv_lat;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && slv_en) begin
               av_readdatavalid = 1'b1;
               av_readdata      = slv_rdata;
            end
         end
         prev_read = av_read;
      end
   end

   // ----------------------------------------------------------- ring player
   logic [68:0] stim_q[$];
   logic [68:0] out_q[$];
   logic [68:0] resp_q[$];
   int          wr_cycles, rd_cycles, wr_first, rd_first, busy_cycles;
   logic [21:0] st_addr;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;

   function automatic logic [68:0] pkt(input logic v, input logic p, input logic w,
                                       input logic [5:0] id, input logic [3:0] m,
                                       input logic [21:0] a, input logic [1:0] s,
                                       input logic [31:0] d);
      return {v, p, w, id, m, a, s, d};
   endfunction

   // Drives stim_q[i] for cycle i (zeros after the end). out_q[i] is rcn_out
   // sampled after that cycle, so a forwarded stim_q[i] lands in out_q[i+1].
   task automatic play(input int n);
      out_q.delete();
      resp_q.delete();
      wr_cycles = 0; rd_cycles = 0; wr_first = -1; rd_first = -1; busy_cycles = 0;
      for (int i = 0; i < n; i++) begin
         rcn_in = (i < stim_q.size()) ? stim_q[i] : '0;
         @(negedge av_clk);
         out_q.push_back(rcn_out);
         if (rcn_out[68] && !rcn_out[67]) resp_q.push_back(rcn_out);
         if (av_write) begin
            if (wr_first < 0) wr_first = i;
            wr_cycles++;
            st_addr = av_address; st_be = av_byteenable; st_wdata = av_writedata;
         end
         if (av_read) begin
            if (rd_first < 0) rd_first = i;
            rd_cycles++;
            st_addr = av_address; st_be = av_byteenable;
         end
         if (busy) busy_cycles++;
      end
      rcn_in = '0;
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      av_rst_n = 1'b0;
      rcn_in   = pkt(1, 1, 1, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'hFFFF_FFFF);
      repeat (3) @(negedge av_clk);
      n_cmp++;
      if (rcn_out !== 69'd0) begin
         n_bad++; $display("FAIL reset_rcn_out: got %h want 0", rcn_out);
      end
      n_cmp++;
      if ({av_read, av_write, busy} !== 3'b000) begin
         n_bad++; $display("FAIL reset_strobes: got rd=%b wr=%b busy=%b want 000",
                           av_read, av_write, busy);
      end
      n_cmp++;
      if ({av_address, av_byteenable, av_writedata} !== 58'd0) begin
         n_bad++; $display("FAIL reset_av_bus: got a=%h be=%h wd=%h want 0",
                           av_address, av_byteenable, av_writedata);
      end
      rcn_in   = '0;
      av_rst_n = 1'b1;
      repeat (2) @(negedge av_clk);
   endtask

   task automatic test_write();
      logic [68:0] exp;
      slv_wait = 0;
      stim_q = '{pkt(1, 1, 1, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'h1234_5678)};
      play(8);
      exp = pkt(1, 0, 1, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'h1234_5678);
      n_cmp++;
      if (wr_cycles !== 1 || rd_cycles !== 0) begin
         n_bad++; $display("FAIL wr_strobe_len: got wr=%0d rd=%0d want 1/0", wr_cycles, rd_cycles);
      end
      n_cmp++;
      if (wr_first !== 1) begin
         n_bad++; $display("FAIL wr_latency: got cycle %0d want 1", wr_first);
      end
      n_cmp++;
      if ({st_addr, st_be, st_wdata} !== {22'h000010, 4'hF, 32'h1234_5678}) begin
         n_bad++; $display("FAIL wr_av_fields: got a=%h be=%h wd=%h want 000010/f/12345678",
                           st_addr, st_be, st_wdata);
      end
      n_cmp++;
      if (out_q[1] !== 69'd0) begin
         n_bad++; $display("FAIL wr_removed: got %h want 0", out_q[1]);
      end
      n_cmp++;
      if (out_q[3] !== exp) begin
         n_bad++; $display("FAIL wr_response: got %h want %h", out_q[3], exp);
      end
      n_cmp++;
      if (resp_q.size() !== 1) begin
         n_bad++; $display("FAIL wr_resp_count: got %0d want 1", resp_q.size());
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL wr_busy_end: got %b want 0", busy);
      end
   endtask

   task automatic test_read_wait();
      logic [68:0] exp;
      slv_wait = 3; slv_lat = 2; slv_rdata = 32'hCAFE_F00D;
      stim_q = '{pkt(1, 1, 0, 6'h05, 4'h3, 22'h000020, 2'd2, 32'h0)};
      play(14);
      exp = pkt(1, 0, 0, 6'h05, 4'h3, 22'h000020, 2'd2, 32'hCAFE_F00D);
      n_cmp++;
      if (rd_cycles !== 4 || wr_cycles !== 0) begin
         n_bad++; $display("FAIL rd_strobe_len: got rd=%0d wr=%0d want 4/0", rd_cycles, wr_cycles);
      end
      n_cmp++;
      if (rd_first !== 1 || st_addr !== 22'h000020 || st_be !== 4'h3) begin
         n_bad++; $display("FAIL rd_av_fields: got first=%0d a=%h be=%h want 1/000020/3",
                           rd_first, st_addr, st_be);
      end
      n_cmp++;
      if (resp_q.size() !== 1) begin
         n_bad++; $display("FAIL rd_resp_count: got %0d want 1", resp_q.size());
      end else begin
         n_cmp++;
         if (resp_q[0] !== exp) begin
            n_bad++; $display("FAIL rd_response: got %h want %h", resp_q[0], exp);
         end
      end
      n_cmp++;
      if (out_q[8] !== exp) begin
         n_bad++; $display("FAIL rd_resp_slot: got %h want %h", out_q[8], exp);
      end
   endtask

   task automatic test_full_ring();
      logic [68:0] exp;
      slv_wait = 0; slv_lat = 1; slv_rdata = 32'hA5A5_5A5A;
      stim_q = '{pkt(1, 1, 0, 6'h11, 4'hC, 22'h000024, 2'd3, 32'h0)};
      for (int i = 1; i < 8; i++) begin
         if (i % 2 == 1)
            stim_q.push_back(pkt(1, 1, 0, 6'(i), 4'hF, 22'h200000 | 22'(i), 2'(i), 32'hF000_0000 + i));
         else
            stim_q.push_back(pkt(1, 0, 1, 6'(i), 4'h1, 22'h000010, 2'(i), 32'h0E00_0000 + i));
      end
      play(14);
      exp = pkt(1, 0, 0, 6'h11, 4'hC, 22'h000024, 2'd3, 32'hA5A5_5A5A);
      for (int i = 1; i < 8; i++) begin
         n_cmp++;
         if (out_q[i+1] !== stim_q[i]) begin
            n_bad++; $display("FAIL full_fwd[%0d]: got %h want %h", i, out_q[i+1], stim_q[i]);
         end
      end
      n_cmp++;
      if (out_q[9] !== exp) begin
         n_bad++; $display("FAIL full_first_empty: got %h want %h", out_q[9], exp);
      end
      n_cmp++;
      if (resp_q.size() !== 4) begin
         // three foreign responses plus ours
         n_bad++; $display("FAIL full_resp_count: got %0d want 4", resp_q.size());
      end
   endtask

   task automatic test_second_hit();
      logic [68:0] a_req, b_req, a_exp, b_exp;
      slv_wait = 0; slv_lat = 4; slv_rdata = 32'h1357_9BDF;
      a_req = pkt(1, 1, 0, 6'h01, 4'hF, 22'h000030, 2'd0, 32'h0);
      b_req = pkt(1, 1, 1, 6'h02, 4'h6, 22'h000040, 2'd1, 32'h0246_8ACE);
      a_exp = pkt(1, 0, 0, 6'h01, 4'hF, 22'h000030, 2'd0, 32'h1357_9BDF);
      b_exp = pkt(1, 0, 1, 6'h02, 4'h6, 22'h000040, 2'd1, 32'h0246_8ACE);
      stim_q = '{a_req, 69'd0, b_req, 69'd0, 69'd0, 69'd0, 69'd0, b_req};
      play(16);
      n_cmp++;
      if (out_q[3] !== b_req) begin
         n_bad++; $display("FAIL b2b_pass_through: got %h want %h", out_q[3], b_req);
      end
      n_cmp++;
      if (wr_cycles !== 1 || wr_first !== 8 || st_wdata !== 32'h0246_8ACE) begin
         n_bad++; $display("FAIL b2b_retry_write: got n=%0d first=%0d wd=%h want 1/8/02468ace",
                           wr_cycles, wr_first, st_wdata);
      end
      n_cmp++;
      if (resp_q.size() !== 2) begin
         n_bad++; $display("FAIL b2b_resp_count: got %0d want 2", resp_q.size());
      end else begin
         n_cmp++;
         if (resp_q[0] !== a_exp || resp_q[1] !== b_exp) begin
            n_bad++; $display("FAIL b2b_resp_order: got %h,%h want %h,%h",
                              resp_q[0], resp_q[1], a_exp, b_exp);
         end
      end
   endtask

   task automatic test_miss_forward();
      stim_q = '{pkt(1, 1, 0, 6'h07, 4'hF, 22'h100000, 2'd0, 32'h55AA_55AA),
                 pkt(1, 0, 1, 6'h08, 4'hF, 22'h000010, 2'd1, 32'h1111_2222),
                 pkt(0, 1, 1, 6'h09, 4'hF, 22'h000010, 2'd2, 32'h3333_4444)};
      play(6);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (out_q[i+1] !== stim_q[i]) begin
            n_bad++; $display("FAIL miss_fwd[%0d]: got %h want %h", i, out_q[i+1], stim_q[i]);
         end
      end
      n_cmp++;
      if (wr_cycles + rd_cycles + busy_cycles !== 0) begin
         n_bad++; $display("FAIL miss_no_strobe: got wr=%0d rd=%0d busy=%0d want 0",
                           wr_cycles, rd_cycles, busy_cycles);
      end
   endtask

   task automatic test_reset_mid();
      logic [68:0] fgn;
      fgn = pkt(1, 0, 1, 6'h2A, 4'h9, 22'h123456, 2'd0, 32'hFEED_FACE);
      // Reset while the read is stalled in CMD.
      slv_wait = 100; slv_lat = 30; slv_rdata = 32'h7777_7777;
      stim_q = '{pkt(1, 1, 0, 6'h0B, 4'hF, 22'h000054, 2'd0, 32'h0)};
      play(3);
      n_cmp++;
      if (av_read !== 1'b1) begin
         n_bad++; $display("FAIL rstcmd_pre: got av_read=%b want 1", av_read);
      end
      av_rst_n = 1'b0;
      @(negedge av_clk);
      n_cmp++;
      if ({av_read, av_write, busy} !== 3'b000) begin
         n_bad++; $display("FAIL rstcmd_strobe: got rd=%b wr=%b busy=%b want 000",
                           av_read, av_write, busy);
      end
      av_rst_n = 1'b1;
      // Reset while waiting for read data.
      slv_wait = 0;
      stim_q = '{pkt(1, 1, 0, 6'h0A, 4'hF, 22'h000050, 2'd1, 32'h0), 69'd0, 69'd0, 69'd0, fgn};
      play(6);
      n_cmp++;
      if (busy !== 1'b1 || rcn_out !== fgn) begin
         n_bad++; $display("FAIL rstrd_pre: got busy=%b out=%h want 1/%h", busy, rcn_out, fgn);
      end
      av_rst_n = 1'b0;
      rcn_in   = fgn;
      @(negedge av_clk);
      n_cmp++;
      if (rcn_out !== 69'd0 || {av_read, av_write, busy} !== 3'b000) begin
         n_bad++; $display("FAIL rstrd_state: got out=%h rd=%b wr=%b busy=%b want 0",
                           rcn_out, av_read, av_write, busy);
      end
      av_rst_n = 1'b1;
      stim_q.delete();
      // The stale read data arrives later while idle and must be ignored.
      play(40);
      n_cmp++;
      if (resp_q.size() !== 0 || busy_cycles !== 0) begin
         n_bad++; $display("FAIL rstrd_no_resp: got resp=%0d busy=%0d want 0/0",
                           resp_q.size(), busy_cycles);
      end
   endtask

`ifdef RCN2AV_TIMEOUT_EN
   task automatic test_timeout();
      logic [68:0] exp;
      slv_wait = 0; slv_lat = 20; slv_rdata = 32'h1111_1111;
      stim_q = '{pkt(1, 1, 0, 6'h0C, 4'hF, 22'h000060, 2'd3, 32'h0)};
      play(40);
      exp = pkt(1, 0, 0, 6'h0C, 4'hF, 22'h000060, 2'd3, 32'hDEAD_DEAD);
      n_cmp++;
      if (resp_q.size() !== 1) begin
         n_bad++; $display("FAIL timeout_count: got %0d want 1", resp_q.size());
      end else begin
         n_cmp++;
         if (resp_q[0] !== exp) begin
            n_bad++; $display("FAIL timeout_resp: got %h want %h", resp_q[0], exp);
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rcn_in   = '0;
      av_rst_n = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_full_ring();
      test_second_hit();
      test_miss_forward();
      test_reset_mid();
`ifdef RCN2AV_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
